// File: rtl/frame_buf_arbiter.sv
// ADC frame buffer owner: arbitrates the 512x16 SRAM between ADC, AC and RO,
// tracks the circular head frame and write-protects it.
module frame_buf_arbiter #(
  parameter int DEBUG_BUS_SIZE = 4,
  parameter bit RR_EN          = 1'b1
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      buf_clr,
  input  logic                      adc_req,
  input  logic [5:0]                adc_chan,
  input  logic [15:0]               adc_wdata,
  input  logic                      adc_frame_done,
  input  logic                      ac_req,
  input  logic                      ac_we,
  input  logic [8:0]                ac_addr,
  input  logic [15:0]               ac_wdata,
  output logic                      ac_gnt,
  output logic                      ac_rvalid,
  input  logic                      ro_req,
  input  logic [8:0]                ro_addr,
  output logic                      ro_gnt,
  output logic                      ro_rvalid,
  output logic [15:0]               rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [8:0]                mem_addr,
  output logic [15:0]               mem_din,
  input  logic [15:0]               mem_dout,
  output logic [2:0]                mem_head_ptr,
  output logic                      frame_rdy,
  output logic [3:0]                fill_cnt,
  output logic                      collision_err,
  output logic [DEBUG_BUS_SIZE-1:0] debug
);

  localparam logic WIN_AC = 1'b0;
  localparam logic WIN_RO = 1'b1;

  logic last_win;
  logic ac_first;
  logic collide;

  // AC takes a tie when RR is off, or when RO had the last grant
  assign ac_first = !RR_EN || (last_win == WIN_RO);

  assign ac_gnt = !adc_req && ac_req && (!ro_req || ac_first);
  assign ro_gnt = !adc_req && ro_req && !(ac_req && ac_first);

  assign collide = ac_gnt && ac_we &&
                   (ac_addr[8:6] == mem_head_ptr);

  assign rdata = mem_dout;

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    unique case (1'b1)
      adc_req: begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {mem_head_ptr, adc_chan};
        mem_din  = adc_wdata;
      end
      ac_gnt: begin
        if (!collide) begin
          mem_en   = 1'b1;
          mem_we   = ac_we;
          mem_addr = ac_addr;
          mem_din  = ac_we ? ac_wdata : 16'h0;
        end
      end
      ro_gnt: begin
        mem_en   = 1'b1;
        mem_addr = ro_addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    debug      = '0;
    debug[3:0] = {last_win, ro_gnt, ac_gnt, adc_req};
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      mem_head_ptr  <= 3'd0;
      fill_cnt      <= 4'd0;
      collision_err <= 1'b0;
      last_win      <= WIN_RO;
      frame_rdy     <= 1'b0;
      ac_rvalid     <= 1'b0;
      ro_rvalid     <= 1'b0;
    end else if (buf_clr) begin
      mem_head_ptr  <= 3'd0;
      fill_cnt      <= 4'd0;
      collision_err <= 1'b0;
      last_win      <= WIN_RO;
      frame_rdy     <= 1'b0;
      ac_rvalid     <= 1'b0;
      ro_rvalid     <= 1'b0;
    end else begin
      ac_rvalid <= ac_gnt && !ac_we;
      ro_rvalid <= ro_gnt;
      frame_rdy <= adc_frame_done;
      if (collide)
        collision_err <= 1'b1;
      if (ac_gnt)
        last_win <= WIN_AC;
      else if (ro_gnt)
        last_win <= WIN_RO;
      if (adc_frame_done) begin
        mem_head_ptr <= mem_head_ptr + 3'd1;
        if (fill_cnt != 4'd8)
          fill_cnt <= fill_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_frame_buf_arbiter.sv
// Directed bench for frame_buf_arbiter: vector table for arbitration and
// muxing, hand sequences for latency, head advance, protection and clear.
module tb_frame_buf_arbiter;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        buf_clr, adc_req, adc_frame_done;
  logic [5:0]  adc_chan;
  logic [15:0] adc_wdata, ac_wdata, mem_dout;
  logic        ac_req, ac_we, ro_req;
  logic [8:0]  ac_addr, ro_addr;

  logic        ac_gnt, ac_rvalid, ro_gnt, ro_rvalid;
  logic [15:0] rdata, mem_din;
  logic        mem_en, mem_we;
  logic [8:0]  mem_addr;
  logic [2:0]  mem_head_ptr;
  logic        frame_rdy, collision_err;
  logic [3:0]  fill_cnt, debug;

  logic        f_ac_gnt, f_ac_rvalid, f_ro_gnt, f_ro_rvalid;
  logic [15:0] f_rdata, f_mem_din;
  logic        f_mem_en, f_mem_we;
  logic [8:0]  f_mem_addr;
  logic [2:0]  f_head;
  logic        f_frame_rdy, f_err;
  logic [3:0]  f_fill, f_debug;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  frame_buf_arbiter #(.DEBUG_BUS_SIZE(4), .RR_EN(1'b1)) dut (
    .clk(clk), .rstb(rstb), .buf_clr(buf_clr),
    .adc_req(adc_req), .adc_chan(adc_chan), .adc_wdata(adc_wdata),
    .adc_frame_done(adc_frame_done),
    .ac_req(ac_req), .ac_we(ac_we), .ac_addr(ac_addr),
    .ac_wdata(ac_wdata), .ac_gnt(ac_gnt), .ac_rvalid(ac_rvalid),
    .ro_req(ro_req), .ro_addr(ro_addr), .ro_gnt(ro_gnt),
    .ro_rvalid(ro_rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_head_ptr(mem_head_ptr), .frame_rdy(frame_rdy),
    .fill_cnt(fill_cnt), .collision_err(collision_err), .debug(debug)
  );

  frame_buf_arbiter #(.DEBUG_BUS_SIZE(4), .RR_EN(1'b0)) dut_fix (
    .clk(clk), .rstb(rstb), .buf_clr(buf_clr),
    .adc_req(adc_req), .adc_chan(adc_chan), .adc_wdata(adc_wdata),
    .adc_frame_done(adc_frame_done),
    .ac_req(ac_req), .ac_we(ac_we), .ac_addr(ac_addr),
    .ac_wdata(ac_wdata), .ac_gnt(f_ac_gnt), .ac_rvalid(f_ac_rvalid),
    .ro_req(ro_req), .ro_addr(ro_addr), .ro_gnt(f_ro_gnt),
    .ro_rvalid(f_ro_rvalid), .rdata(f_rdata),
    .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_addr(f_mem_addr),
    .mem_din(f_mem_din), .mem_dout(mem_dout),
    .mem_head_ptr(f_head), .frame_rdy(f_frame_rdy),
    .fill_cnt(f_fill), .collision_err(f_err), .debug(f_debug)
  );

  typedef struct {
    logic        adc;
    logic [5:0]  chan;
    logic [15:0] adata;
    logic        ac;
    logic        we;
    logic [8:0]  aaddr;
    logic [15:0] awdata;
    logic        ro;
    logic [8:0]  raddr;
    logic        x_acg;
    logic        x_rog;
    logic        x_en;
    logic        x_we;
    logic [8:0]  x_addr;
    logic [15:0] x_din;
    logic        x_acg_fix;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endtask

  task automatic idle();
    buf_clr = 0; adc_req = 0; adc_chan = '0; adc_wdata = '0;
    adc_frame_done = 0; ac_req = 0; ac_we = 0; ac_addr = '0;
    ac_wdata = '0; ro_req = 0; ro_addr = '0; mem_dout = '0;
  endtask

  task automatic frame_pulses(input int n);
    for (int k = 0; k < n; k++) begin
      adc_frame_done = 1;
      @(negedge clk);
    end
    adc_frame_done = 0;
  endtask

  initial begin
    // head=0, last winner RO at the start of the table
    vt[0] = '{0,0,16'h0,    0,0,9'h000,16'h0,    0,9'h000,
              0,0,0,0,9'h000,16'h0,    0};
    vt[1] = '{1,5,16'h1234, 1,0,9'h100,16'h0,    0,9'h000,
              0,0,1,1,9'h005,16'h1234, 0};
    vt[2] = '{0,0,16'h0,    1,0,9'h0C1,16'h0,    1,9'h040,
              1,0,1,0,9'h0C1,16'h0,    1};
    vt[3] = '{0,0,16'h0,    1,0,9'h0C1,16'h0,    1,9'h040,
              0,1,1,0,9'h040,16'h0,    1};
    vt[4] = '{0,0,16'h0,    1,0,9'h0C1,16'h0,    1,9'h040,
              1,0,1,0,9'h0C1,16'h0,    1};
    vt[5] = '{0,0,16'h0,    1,0,9'h0C1,16'h0,    1,9'h040,
              0,1,1,0,9'h040,16'h0,    1};
    vt[6] = '{0,0,16'h0,    1,1,9'h045,16'hABCD, 0,9'h000,
              1,0,1,1,9'h045,16'hABCD, 1};
    vt[7] = '{0,0,16'h0,    0,0,9'h000,16'h0,    1,9'h1FF,
              0,1,1,0,9'h1FF,16'h0,    0};
    vt[8] = '{0,0,16'h0,    1,1,9'h03F,16'h5555, 0,9'h000,
              1,0,0,0,9'h000,16'h0,    1};

    idle();
    repeat (2) @(negedge clk);
    chk("rst_head", 32'(mem_head_ptr), 0);
    chk("rst_fill", 32'(fill_cnt), 0);
    chk("rst_err", 32'(collision_err), 0);
    chk("rst_frdy", 32'(frame_rdy), 0);
    chk("rst_rv", 32'({ac_rvalid, ro_rvalid}), 0);
    chk("rst_gnt", 32'({ac_gnt, ro_gnt}), 0);
    rstb = 1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      adc_req = vt[i].adc; adc_chan = vt[i].chan;
      adc_wdata = vt[i].adata; ac_req = vt[i].ac;
      ac_we = vt[i].we; ac_addr = vt[i].aaddr;
      ac_wdata = vt[i].awdata; ro_req = vt[i].ro;
      ro_addr = vt[i].raddr;
      #1;
      chk($sformatf("v%0d_acg", i), 32'(ac_gnt), 32'(vt[i].x_acg));
      chk($sformatf("v%0d_rog", i), 32'(ro_gnt), 32'(vt[i].x_rog));
      chk($sformatf("v%0d_en", i), 32'(mem_en), 32'(vt[i].x_en));
      chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(vt[i].x_we));
      chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vt[i].x_addr));
      chk($sformatf("v%0d_din", i), 32'(mem_din), 32'(vt[i].x_din));
      chk($sformatf("v%0d_acg_fix", i), 32'(f_ac_gnt),
          32'(vt[i].x_acg_fix));
      @(negedge clk);
    end
    idle();
    chk("tbl_err_set", 32'(collision_err), 1);

    // RO read latency
    ro_req = 1; ro_addr = 9'h040;
    #1 chk("ro_gnt", 32'(ro_gnt), 1);
    @(negedge clk);
    idle(); mem_dout = 16'hBEEF;
    #1;
    chk("ro_rv", 32'(ro_rvalid), 1);
    chk("ro_rdata", 32'(rdata), 32'h0000BEEF);
    chk("ro_ac_rv", 32'(ac_rvalid), 0);
    ac_req = 1; ac_we = 1; ac_addr = 9'h045;
    @(negedge clk);
    idle();
    chk("ro_rv_drop", 32'(ro_rvalid), 0);
    chk("wr_no_rv", 32'(ac_rvalid), 0);
    ac_req = 1; ac_addr = 9'h1C0;
    @(negedge clk);
    idle();
    chk("ac_rv", 32'(ac_rvalid), 1);

    buf_clr = 1;
    @(negedge clk);
    buf_clr = 0;
    chk("clr_err", 32'(collision_err), 0);

    // 9 head advances, ADC write in the same cycle as the third
    for (int i = 0; i < 9; i++) begin
      adc_frame_done = 1;
      if (i == 2) begin
        adc_req = 1; adc_chan = 6'd5; adc_wdata = 16'h1234;
        ac_req = 1; ac_addr = 9'h100;
        #1;
        chk("adc_old_head", 32'(mem_addr), 32'h085);
        chk("adc_blocks_ac", 32'(ac_gnt), 0);
      end
      @(negedge clk);
      idle();
      chk($sformatf("fd%0d_rdy", i), 32'(frame_rdy), 1);
      chk($sformatf("fd%0d_head", i), 32'(mem_head_ptr), 32'((i + 1) % 8));
      chk($sformatf("fd%0d_fill", i), 32'(fill_cnt),
          32'((i + 1 > 8) ? 8 : i + 1));
    end
    @(negedge clk);
    chk("fd_rdy_low", 32'(frame_rdy), 0);

    buf_clr = 1;
    @(negedge clk);
    buf_clr = 0;
    frame_pulses(3);
    chk("head3", 32'(mem_head_ptr), 3);
    ac_req = 1; ac_we = 1; ac_addr = 9'h0C0; ac_wdata = 16'h7777;
    #1;
    chk("prot_gnt", 32'(ac_gnt), 1);
    chk("prot_en", 32'(mem_en), 0);
    chk("prot_we", 32'(mem_we), 0);
    @(negedge clk);
    idle();
    chk("prot_err", 32'(collision_err), 1);
    @(negedge clk);
    chk("prot_sticky", 32'(collision_err), 1);
    buf_clr = 1; ro_req = 1; ro_addr = 9'h011;
    #1 chk("clr_gnt", 32'(ro_gnt), 1);
    @(negedge clk);
    idle();
    chk("clr_err2", 32'(collision_err), 0);
    chk("clr_flush", 32'(ro_rvalid), 0);
    chk("clr_head", 32'(mem_head_ptr), 0);

    frame_pulses(6);
    chk("head6", 32'(mem_head_ptr), 6);
    adc_frame_done = 1; buf_clr = 1;
    @(negedge clk);
    idle();
    chk("clrfd_head", 32'(mem_head_ptr), 0);
    chk("clrfd_fill", 32'(fill_cnt), 0);
    chk("clrfd_rdy", 32'(frame_rdy), 0);

    // async reset while a read is in flight
    frame_pulses(1);
    ro_req = 1; ro_addr = 9'h055;
    @(posedge clk);
    #1 idle();
    rstb = 0;
    #1;
    chk("arst_rv", 32'(ro_rvalid), 0);
    chk("arst_head", 32'(mem_head_ptr), 0);
    chk("arst_fill", 32'(fill_cnt), 0);
    @(negedge clk);
    rstb = 1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
